// File: rtl/carrier_nco_pkg.sv
// Shared constants and level encoding for the carrier NCO.
package carrier_nco_pkg;

  localparam int ACC_W = 30;
  localparam int FC_W  = 29;
  localparam int CYC_W = 22;
  localparam int PH_W  = 10;

  // Two-bit sign/magnitude replica level, {sign, mag}.
  typedef enum logic [1:0] {
    LVL_POS1 = 2'b00,
    LVL_POS2 = 2'b01,
    LVL_NEG1 = 2'b10,
    LVL_NEG2 = 2'b11
  } level_t;

endpackage

// File: rtl/carrier_nco_lut.sv
// Maps the 3-bit phase key (45-degree sectors) onto cosine (I) and sine (Q)
// sign/magnitude replica levels.
module carrier_nco_lut
  import carrier_nco_pkg::*;
(
  input  logic [2:0] phase_key,
  output logic       i_sign,
  output logic       i_mag,
  output logic       q_sign,
  output logic       q_mag
);

  level_t i_lvl;
  level_t q_lvl;

  // Sector table: I follows cosine, Q follows sine, both quantised to +/-1, +/-2.
  always_comb begin
    i_lvl = LVL_POS2;
    q_lvl = LVL_POS1;
    case (phase_key)
      3'd0: begin i_lvl = LVL_POS2; q_lvl = LVL_POS1; end
      3'd1: begin i_lvl = LVL_POS1; q_lvl = LVL_POS2; end
      3'd2: begin i_lvl = LVL_NEG1; q_lvl = LVL_POS2; end
      3'd3: begin i_lvl = LVL_NEG2; q_lvl = LVL_POS1; end
      3'd4: begin i_lvl = LVL_NEG2; q_lvl = LVL_NEG1; end
      3'd5: begin i_lvl = LVL_NEG1; q_lvl = LVL_NEG2; end
      3'd6: begin i_lvl = LVL_POS1; q_lvl = LVL_NEG2; end
      3'd7: begin i_lvl = LVL_POS2; q_lvl = LVL_NEG1; end
      default: begin i_lvl = LVL_POS2; q_lvl = LVL_POS1; end
    endcase
  end

  assign {i_sign, i_mag} = i_lvl;
  assign {q_sign, q_mag} = q_lvl;

endmodule

// File: rtl/carrier_nco.sv
// Carrier NCO for one correlator channel: phase accumulator, full-cycle
// counter with TIC-latched readout, and 2-bit I/Q carrier replicas.
module carrier_nco
  import carrier_nco_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tic_enable,
  input  logic [FC_W-1:0]        f_control,
  output logic [CYC_W+PH_W-1:0]  carrier_val,
  output logic                   i_sign,
  output logic                   i_mag,
  output logic                   q_sign,
  output logic                   q_mag
);

  logic [ACC_W-1:0] accum;
  logic [CYC_W-1:0] cycle_count;
  logic [ACC_W:0]   sum;
  logic             carry;

  // Zero-extended frequency word added to the current phase; bit ACC_W is the wrap.
  assign sum   = {1'b0, accum} + {{(ACC_W + 1 - FC_W){1'b0}}, f_control};
  assign carry = sum[ACC_W];

  // Phase accumulator advances by the frequency word every clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accum <= '0;
    end else begin
      accum <= sum[ACC_W-1:0];
    end
  end

  // Count carrier cycles; on TIC latch count+phase and restart with this edge's carry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_count <= '0;
      carrier_val <= '0;
    end else if (tic_enable) begin
      carrier_val <= {cycle_count, accum[ACC_W-1 -: PH_W]};
      cycle_count <= {{(CYC_W - 1){1'b0}}, carry};
    end else begin
      cycle_count <= cycle_count + {{(CYC_W - 1){1'b0}}, carry};
    end
  end

  carrier_nco_lut u_lut (
    .phase_key (accum[ACC_W-1 -: 3]),
    .i_sign    (i_sign),
    .i_mag     (i_mag),
    .q_sign    (q_sign),
    .q_mag     (q_mag)
  );

endmodule

// File: tb/tb_carrier_nco.sv
// Directed self-checking bench for carrier_nco with hand-computed expectations.
module tb_carrier_nco;

  logic        clk;
  logic        rstn;
  logic        tic_enable;
  logic [28:0] f_control;
  logic [31:0] carrier_val;
  logic        i_sign, i_mag, q_sign, q_mag;

  int vectorCount;
  int errorCount;

  // Expected I and Q levels for phase key 0..7, {sign, mag}.
  logic [1:0] expI [8];
  logic [1:0] expQ [8];

  carrier_nco dut (
    .clk         (clk),
    .rstn        (rstn),
    .tic_enable  (tic_enable),
    .f_control   (f_control),
    .carrier_val (carrier_val),
    .i_sign      (i_sign),
    .i_mag       (i_mag),
    .q_sign      (q_sign),
    .q_mag       (q_mag)
  );

  // 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, run n rising edges, end back on a falling edge.
  task automatic applyStimulus(input logic tic, input logic [28:0] f, input int n);
    tic_enable = tic;
    f_control  = f;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    tic_enable = 1'b0;
  endtask

  // Hold reset for a few clocks, then release on a falling edge with f_control=0.
  task automatic resetDut();
    tic_enable = 1'b0;
    f_control  = '0;
    rstn       = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] iq();
    return {28'd0, i_sign, i_mag, q_sign, q_mag};
  endfunction

  initial begin
    vectorCount = 0;
    errorCount  = 0;
    expI = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01};
    expQ = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
    rstn       = 1'b0;
    tic_enable = 1'b0;
    f_control  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_val", carrier_val, 32'd0);
    checkOutput("reset_iq", iq(), 32'h4);
    rstn = 1'b1;

    // Frozen phase with a zero frequency word.
    applyStimulus(1'b0, 29'd0, 100);
    checkOutput("f0_iq", iq(), 32'h4);
    applyStimulus(1'b1, 29'd0, 1);
    checkOutput("f0_tic", carrier_val, 32'd0);

    // One sector per clock: walk the whole table twice.
    resetDut();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 29'h800_0000, 1);
      checkOutput($sformatf("lut_p%0d", k % 8), iq(), {28'd0, expI[k % 8], expQ[k % 8]});
    end

    // Ten carries in 80 clocks, then two in the following 16.
    resetDut();
    applyStimulus(1'b0, 29'h800_0000, 80);
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("tic_first", carrier_val, {22'd10, 10'd0});
    applyStimulus(1'b0, 29'h800_0000, 15);
    checkOutput("tic_hold", carrier_val, {22'd10, 10'd0});
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("tic_second", carrier_val, {22'd2, 10'd0});

    // Fractional phase readout.
    resetDut();
    applyStimulus(1'b0, 29'h10_0000, 5);
    applyStimulus(1'b1, 29'h10_0000, 1);
    checkOutput("fraction", carrier_val, 32'd5);

    // TIC on the edge that carries: that carry lands in the next interval.
    resetDut();
    applyStimulus(1'b0, 29'h800_0000, 7);
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("tic_carry_latch", carrier_val, {22'd0, 10'd896});
    applyStimulus(1'b0, 29'h800_0000, 3);
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("tic_carry_next", carrier_val, {22'd1, 10'd384});

    // Maximum frequency word.
    resetDut();
    applyStimulus(1'b0, 29'h1FFF_FFFF, 2);
    checkOutput("fmax_p7", iq(), {28'd0, expI[7], expQ[7]});
    applyStimulus(1'b0, 29'h1FFF_FFFF, 1);
    checkOutput("fmax_p3", iq(), {28'd0, expI[3], expQ[3]});
    applyStimulus(1'b1, 29'h1FFF_FFFF, 1);
    checkOutput("fmax_tic", carrier_val, {22'd1, 10'd511});

    // Asynchronous reset between clock edges.
    resetDut();
    applyStimulus(1'b0, 29'h800_0000, 13);
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("pre_async", carrier_val, {22'd1, 10'd640});
    applyStimulus(1'b0, 29'h800_0000, 2);
    tic_enable = 1'b1;
    #3;
    rstn = 1'b0;
    #2;
    checkOutput("async_val", carrier_val, 32'd0);
    checkOutput("async_iq", iq(), 32'h4);
    @(negedge clk);
    tic_enable = 1'b0;
    rstn = 1'b1;
    applyStimulus(1'b0, 29'h800_0000, 8);
    applyStimulus(1'b1, 29'h800_0000, 1);
    checkOutput("post_async", carrier_val, {22'd1, 10'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
